mindy_cfg_regs: RTL and testbench

//  Parametrised AXI4-Lite configuration register file for mindy_core. Handles NUM_RGN 64-bit

---
 rtl/mindy_cfg_pkg.sv | 36 +++
 rtl/mindy_cfg_regs.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_mindy_cfg_regs.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mindy_cfg_pkg.sv
// Shared offsets, response codes, FSM state types and the WSTRB merge helper
// for the mindy_core configuration register file.
package mindy_cfg_pkg;

    localparam logic [7:0] OFS_ID          = 8'h00;
    localparam logic [7:0] OFS_CONTROL     = 8'h04;
    localparam logic [7:0] OFS_FRAME_SIZE  = 8'h08;
    localparam logic [7:0] OFS_PACKET_SIZE = 8'h0C;
    localparam logic [7:0] OFS_PPG         = 8'h10;
    localparam logic [7:0] OFS_SENSOR_HDR  = 8'h14;
    localparam logic [7:0] OFS_HDR_ENABLE  = 8'h18;
    localparam logic [7:0] OFS_RGN_BASE    = 8'h20;
    localparam logic [7:0] OFS_FC_BASE     = 8'h80;
    localparam int unsigned RGN_STRIDE     = 16;

    localparam logic [1:0]  RESP_OKAY      = 2'd0;
    localparam logic [1:0]  RESP_SLVERR    = 2'd2;
    localparam logic [1:0]  RESP_DECERR    = 2'd3;
    localparam logic [15:0] ID_MAGIC       = 16'h4D43;
    localparam logic [31:0] SENSOR_HDR_RST = 32'h0FAAF0AA;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_VALID}        rd_state_e;

    // Byte-lane merge: lanes with a set strobe bit take wdata, others keep old.
    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] m;
        for (int unsigned b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{wstrb[b]}};
        end
        return (old & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/mindy_cfg_regs.sv
// AXI4-Lite configuration register file for mindy_core: staging registers,
// atomic COMMIT to the core-facing active set, CFG_LOCK write guard.
module mindy_cfg_regs
    import mindy_cfg_pkg::*;
#(
    parameter int unsigned NUM_RGN   = 3,
    parameter int unsigned NUM_CH    = 2,
    parameter logic [7:0]  ADDR_MASK = 8'hFF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [32*NUM_CH-1:0]   FRAME_COUNT,
    input  logic                   CFG_LOCK,
    output logic [64*NUM_RGN-1:0]  RGN_ADDR,
    output logic [64*NUM_RGN-1:0]  RGN_SIZE,
    output logic [31:0]            FRAME_SIZE,
    output logic [15:0]            PACKET_SIZE,
    output logic [31:0]            PACKETS_PER_GROUP,
    output logic [31:0]            SENSOR_HDR,
    output logic                   SENSOR_HDR_ENABLE,
    output logic                   CFG_UPDATE,
    input  logic [31:0]            S_AXI_AWADDR,
    input  logic [2:0]             S_AXI_AWPROT,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [31:0]            S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [31:0]            S_AXI_ARADDR,
    input  logic [2:0]             S_AXI_ARPROT,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [31:0]            S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY
);

    wr_state_e   w_state_q;
    logic        aw_held_q, w_held_q, awready_q, wready_q, bvalid_q;
    logic [7:0]  aw_ofs_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q, wr_resp_d;

    rd_state_e   r_state_q;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q, rd_data_d;
    logic [1:0]  rresp_q, rd_resp_d;
    logic [7:0]  ar_ofs;

    logic [31:0] stg_frame_q, stg_ppg_q, stg_hdr_q;
    logic [15:0] stg_packet_q;
    logic        stg_hdr_en_q;
    logic [31:0] act_frame_q, act_ppg_q, act_hdr_q;
    logic [15:0] act_packet_q;
    logic        act_hdr_en_q, cfg_update_q;

    logic                     w_cfg_hit, stg_we, commit;
    logic [NUM_RGN-1:0]       w_rgn_hit, r_rgn_hit;
    logic [NUM_CH-1:0]        w_fc_hit, r_fc_hit;
    logic [NUM_RGN-1:0][31:0] rgn_rdata;
    logic [NUM_CH-1:0][31:0]  fc_rdata;

    logic unused_in;
    assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[31:8], S_AXI_ARADDR[31:8]};

    assign ar_ofs = S_AXI_ARADDR[7:0] & ADDR_MASK & 8'hFC;

    assign w_cfg_hit = (aw_ofs_q == OFS_FRAME_SIZE) || (aw_ofs_q == OFS_PACKET_SIZE) ||
                       (aw_ofs_q == OFS_PPG) || (aw_ofs_q == OFS_SENSOR_HDR) ||
                       (aw_ofs_q == OFS_HDR_ENABLE);
    assign stg_we = (w_state_q == W_EXEC) && !CFG_LOCK && (w_cfg_hit || (|w_rgn_hit));
    assign commit = (w_state_q == W_EXEC) && (aw_ofs_q == OFS_CONTROL) && w_data_q[0] && !CFG_LOCK;

    for (genvar r = 0; r < NUM_RGN; r++) begin : g_rgn
        localparam logic [7:0] BASE = OFS_RGN_BASE + 8'(r * RGN_STRIDE);
        logic [63:0] stg_addr_q, stg_size_q, act_addr_q, act_size_q;
        logic [31:0] r_word;

        assign w_rgn_hit[r] = (aw_ofs_q & 8'hF0) == BASE;
        assign r_rgn_hit[r] = (ar_ofs & 8'hF0) == BASE;

        // Region staging writes (H/L halves) and commit to the active copy.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                stg_addr_q <= '0;
                stg_size_q <= '0;
                act_addr_q <= '0;
                act_size_q <= '0;
            end else begin
                if (stg_we && w_rgn_hit[r]) begin
                    case (aw_ofs_q[3:2])
                        2'd0:    stg_addr_q[63:32] <= strb_merge(stg_addr_q[63:32], w_data_q, w_strb_q);
                        2'd1:    stg_addr_q[31:0]  <= strb_merge(stg_addr_q[31:0],  w_data_q, w_strb_q);
                        2'd2:    stg_size_q[63:32] <= strb_merge(stg_size_q[63:32], w_data_q, w_strb_q);
                        default: stg_size_q[31:0]  <= strb_merge(stg_size_q[31:0],  w_data_q, w_strb_q);
                    endcase
                end
                if (commit) begin
                    act_addr_q <= stg_addr_q;
                    act_size_q <= stg_size_q;
                end
            end
        end

        // Select the staging word addressed by the read offset.
        always_comb begin
            case (ar_ofs[3:2])
                2'd0:    r_word = stg_addr_q[63:32];
                2'd1:    r_word = stg_addr_q[31:0];
                2'd2:    r_word = stg_size_q[63:32];
                default: r_word = stg_size_q[31:0];
            endcase
        end

        assign rgn_rdata[r]          = r_rgn_hit[r] ? r_word : '0;
        assign RGN_ADDR[64*r +: 64]  = act_addr_q;
        assign RGN_SIZE[64*r +: 64]  = act_size_q;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_fc
        localparam logic [7:0] FC_OFS = OFS_FC_BASE + 8'(4 * c);
        assign w_fc_hit[c] = aw_ofs_q == FC_OFS;
        assign r_fc_hit[c] = ar_ofs == FC_OFS;
        assign fc_rdata[c] = r_fc_hit[c] ? FRAME_COUNT[32*c +: 32] : '0;
    end

    // Write response: read-only and locked targets SLVERR, unmapped DECERR.
    always_comb begin
        wr_resp_d = RESP_DECERR;
        if (aw_ofs_q == OFS_CONTROL) begin
            wr_resp_d = (w_data_q[0] && CFG_LOCK) ? RESP_SLVERR : RESP_OKAY;
        end else if ((aw_ofs_q == OFS_ID) || (|w_fc_hit)) begin
            wr_resp_d = RESP_SLVERR;
        end else if (w_cfg_hit || (|w_rgn_hit)) begin
            wr_resp_d = CFG_LOCK ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Read mux over staging values, ID, CONTROL and live frame counters.
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        case (ar_ofs)
            OFS_ID:          rd_data_d = {ID_MAGIC, 8'(NUM_CH), 8'(NUM_RGN)};
            OFS_CONTROL:     rd_data_d = {31'b0, CFG_LOCK};
            OFS_FRAME_SIZE:  rd_data_d = stg_frame_q;
            OFS_PACKET_SIZE: rd_data_d = {16'b0, stg_packet_q};
            OFS_PPG:         rd_data_d = stg_ppg_q;
            OFS_SENSOR_HDR:  rd_data_d = stg_hdr_q;
            OFS_HDR_ENABLE:  rd_data_d = {31'b0, stg_hdr_en_q};
            default: begin
                for (int unsigned i = 0; i < NUM_RGN; i++) rd_data_d = rd_data_d | rgn_rdata[i];
                for (int unsigned i = 0; i < NUM_CH; i++)  rd_data_d = rd_data_d | fc_rdata[i];
                if (!((|r_rgn_hit) || (|r_fc_hit))) rd_resp_d = RESP_DECERR;
            end
        endcase
    end

    // Scalar staging registers take strobe-merged write data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stg_frame_q  <= '0;
            stg_packet_q <= '0;
            stg_ppg_q    <= '0;
            stg_hdr_q    <= SENSOR_HDR_RST;
            stg_hdr_en_q <= 1'b0;
        end else if (stg_we) begin
            case (aw_ofs_q)
                OFS_FRAME_SIZE:  stg_frame_q  <= strb_merge(stg_frame_q, w_data_q, w_strb_q);
                OFS_PACKET_SIZE: stg_packet_q <= 16'(strb_merge({16'b0, stg_packet_q}, w_data_q, w_strb_q));
                OFS_PPG:         stg_ppg_q    <= strb_merge(stg_ppg_q, w_data_q, w_strb_q);
                OFS_SENSOR_HDR:  stg_hdr_q    <= strb_merge(stg_hdr_q, w_data_q, w_strb_q);
                OFS_HDR_ENABLE:  stg_hdr_en_q <= 1'(strb_merge({31'b0, stg_hdr_en_q}, w_data_q, w_strb_q));
                default: ;
            endcase
        end
    end

    // Active set copies staging on COMMIT; CFG_UPDATE marks that edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act_frame_q  <= '0;
            act_packet_q <= '0;
            act_ppg_q    <= '0;
            act_hdr_q    <= SENSOR_HDR_RST;
            act_hdr_en_q <= 1'b0;
            cfg_update_q <= 1'b0;
        end else begin
            cfg_update_q <= commit;
            if (commit) begin
                act_frame_q  <= stg_frame_q;
                act_packet_q <= stg_packet_q;
                act_ppg_q    <= stg_ppg_q;
                act_hdr_q    <= stg_hdr_q;
                act_hdr_en_q <= stg_hdr_en_q;
            end
        end
    end

    // Write channel FSM: independent AW/W capture, execute, hold response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_ofs_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (S_AXI_AWVALID && awready_q) begin
                        aw_ofs_q  <= S_AXI_AWADDR[7:0] & ADDR_MASK & 8'hFC;
                        aw_held_q <= 1'b1;
                        awready_q <= 1'b0;
                    end
                    if (S_AXI_WVALID && wready_q) begin
                        w_data_q <= S_AXI_WDATA;
                        w_strb_q <= S_AXI_WSTRB;
                        w_held_q <= 1'b1;
                        wready_q <= 1'b0;
                    end
                    if (aw_held_q && w_held_q) w_state_q <= W_EXEC;
                end
                W_EXEC: begin
                    bvalid_q  <= 1'b1;
                    bresp_q   <= wr_resp_d;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: data and response captured at the AR handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        rdata_q   <= rd_data_d;
                        rresp_q   <= rd_resp_d;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign FRAME_SIZE        = act_frame_q;
    assign PACKET_SIZE       = act_packet_q;
    assign PACKETS_PER_GROUP = act_ppg_q;
    assign SENSOR_HDR        = act_hdr_q;
    assign SENSOR_HDR_ENABLE = act_hdr_en_q;
    assign CFG_UPDATE        = cfg_update_q;
    assign S_AXI_AWREADY     = awready_q;
    assign S_AXI_WREADY      = wready_q;
    assign S_AXI_BVALID      = bvalid_q;
    assign S_AXI_BRESP       = bresp_q;
    assign S_AXI_ARREADY     = arready_q;
    assign S_AXI_RVALID      = rvalid_q;
    assign S_AXI_RDATA       = rdata_q;
    assign S_AXI_RRESP       = rresp_q;

endmodule

// File: tb/tb_mindy_cfg_regs.sv
// Directed self-checking bench for mindy_cfg_regs (NUM_RGN=3, NUM_CH=2).
module tb_mindy_cfg_regs;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [63:0]  FRAME_COUNT = '0;
    logic         CFG_LOCK = 1'b0;
    logic [191:0] RGN_ADDR, RGN_SIZE;
    logic [31:0]  FRAME_SIZE, PACKETS_PER_GROUP, SENSOR_HDR;
    logic [15:0]  PACKET_SIZE;
    logic         SENSOR_HDR_ENABLE, CFG_UPDATE;
    logic [31:0]  awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]   wstrb = '0;
    logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]   BRESP, RRESP;
    logic [31:0]  RDATA;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    mindy_cfg_regs #(.NUM_RGN(3), .NUM_CH(2), .ADDR_MASK(8'hFF)) dut (
        .clk(clk), .resetn(resetn), .FRAME_COUNT(FRAME_COUNT), .CFG_LOCK(CFG_LOCK),
        .RGN_ADDR(RGN_ADDR), .RGN_SIZE(RGN_SIZE), .FRAME_SIZE(FRAME_SIZE),
        .PACKET_SIZE(PACKET_SIZE), .PACKETS_PER_GROUP(PACKETS_PER_GROUP),
        .SENSOR_HDR(SENSOR_HDR), .SENSOR_HDR_ENABLE(SENSOR_HDR_ENABLE), .CFG_UPDATE(CFG_UPDATE),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    // Count CFG_UPDATE high cycles, sampled away from the active edge.
    always @(negedge clk) if (CFG_UPDATE === 1'b1) upd_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present AW and W together and drop each VALID once its beat is taken.
    task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(aw_done && w_done) && cyc < 30) begin
            aw_hs = awvalid && AWREADY;
            w_hs  = wvalid && WREADY;
            step(1); cyc++;
            if (aw_hs) begin awvalid = 0; aw_done = 1; end
            if (w_hs)  begin wvalid = 0;  w_done = 1;  end
        end
        awvalid = 0; wvalid = 0;
        check_eq("wr_accept", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_b();
        int cyc = 0;
        while (!BVALID && cyc < 30) begin step(1); cyc++; end
        check_eq("wr_bvalid", BVALID, 1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic upd_at_b);
        wr_issue(a, d, s);
        bready = 1;
        wait_b();
        resp = BRESP;
        upd_at_b = CFG_UPDATE;
        step(1);
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic hs = 0;
        int cyc = 0;
        araddr = a; arvalid = 1;
        while (!hs && cyc < 30) begin hs = ARREADY; step(1); cyc++; end
        arvalid = 0;
        cyc = 0;
        while (!RVALID && cyc < 30) begin step(1); cyc++; end
        check_eq("rd_rvalid", RVALID, 1);
        d = RDATA; resp = RRESP;
        rready = 1; step(1); rready = 0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        upd;
    int          u0, stable, cyc;

    initial begin
        // Reset state
        step(3);
        check_eq("rst_rgn_addr", RGN_ADDR, '0);
        check_eq("rst_rgn_size", RGN_SIZE, '0);
        check_eq("rst_frame", FRAME_SIZE, 0);
        check_eq("rst_packet", PACKET_SIZE, 0);
        check_eq("rst_ppg", PACKETS_PER_GROUP, 0);
        check_eq("rst_hdr", SENSOR_HDR, 32'h0FAAF0AA);
        check_eq("rst_hdr_en", SENSOR_HDR_ENABLE, 0);
        check_eq("rst_upd", CFG_UPDATE, 0);
        check_eq("rst_valids", {BVALID, RVALID}, 2'b00);
        check_eq("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
        resetn = 1;
        step(2);

        axi_read(32'h00, rd, rs);
        check_eq("id_data", rd, 32'h4D430203);
        check_eq("id_resp", rs, 2'd0);
        axi_read(32'h14, rd, rs);
        check_eq("hdr_rst_read", rd, 32'h0FAAF0AA);

        // Staging then commit
        axi_write(32'h20, 32'h1, 4'hF, rs, upd);
        check_eq("w20_resp", rs, 2'd0);
        axi_write(32'h24, 32'h80000000, 4'hF, rs, upd);
        check_eq("stg_not_active", RGN_ADDR[63:0], 64'h0);
        axi_read(32'h20, rd, rs);
        check_eq("rd_addr_h", rd, 32'h1);
        axi_read(32'h24, rd, rs);
        check_eq("rd_addr_l", rd, 32'h80000000);
        u0 = upd_cnt;
        axi_write(32'h04, 32'h1, 4'hF, rs, upd);
        check_eq("commit_resp", rs, 2'd0);
        check_eq("commit_upd_at_b", upd, 1);
        check_eq("commit_rgn0", RGN_ADDR[63:0], 64'h1_80000000);
        check_eq("commit_upd_now_low", CFG_UPDATE, 0);
        check_eq("commit_upd_cycles", upd_cnt - u0, 1);

        // Byte strobes
        axi_write(32'h14, 32'hDEADBEEF, 4'b0101, rs, upd);
        axi_read(32'h14, rd, rs);
        check_eq("strb_merge", rd, 32'h0FADF0EF);
        check_eq("strb_active_kept", SENSOR_HDR, 32'h0FAAF0AA);
        axi_write(32'h0C, 32'h12345678, 4'hF, rs, upd);
        axi_read(32'h0C, rd, rs);
        check_eq("pkt_zext", rd, 32'h00005678);
        axi_write(32'h08, 32'h00000100, 4'hF, rs, upd);
        axi_write(32'h08, 32'hFFFFFFFF, 4'h0, rs, upd);
        check_eq("strb0_resp", rs, 2'd0);
        axi_read(32'h08, rd, rs);
        check_eq("strb0_nochange", rd, 32'h100);

        // Error responses
        axi_write(32'h80, 32'h5, 4'hF, rs, upd);
        check_eq("wr_fc_slverr", rs, 2'd2);
        axi_write(32'h00, 32'h5, 4'hF, rs, upd);
        check_eq("wr_id_slverr", rs, 2'd2);
        axi_write(32'h1C, 32'h5, 4'hF, rs, upd);
        check_eq("wr_1c_decerr", rs, 2'd3);
        axi_write(32'h54, 32'h5, 4'hF, rs, upd);
        check_eq("wr_rgn3_decerr", rs, 2'd3);
        axi_read(32'h50, rd, rs);
        check_eq("rd_rgn3_resp", rs, 2'd3);
        check_eq("rd_rgn3_data", rd, 0);
        axi_read(32'h88, rd, rs);
        check_eq("rd_ch2_decerr", rs, 2'd3);

        // Lock guard
        CFG_LOCK = 1;
        axi_write(32'h08, 32'hAAAA5555, 4'hF, rs, upd);
        check_eq("lock_wr_slverr", rs, 2'd2);
        axi_read(32'h08, rd, rs);
        check_eq("lock_wr_nochange", rd, 32'h100);
        axi_read(32'h04, rd, rs);
        check_eq("ctrl_reads_lock", rd, 32'h1);
        u0 = upd_cnt;
        axi_write(32'h04, 32'h1, 4'hF, rs, upd);
        check_eq("lock_commit_slverr", rs, 2'd2);
        check_eq("lock_commit_no_upd", upd_cnt - u0, 0);
        check_eq("lock_frame_kept", FRAME_SIZE, 0);
        axi_write(32'h04, 32'h0, 4'hF, rs, upd);
        check_eq("lock_ctrl0_okay", rs, 2'd0);
        CFG_LOCK = 0;
        u0 = upd_cnt;
        axi_write(32'h04, 32'h1, 4'hF, rs, upd);
        check_eq("commit2_frame", FRAME_SIZE, 32'h100);
        check_eq("commit2_packet", PACKET_SIZE, 16'h5678);
        check_eq("commit2_hdr", SENSOR_HDR, 32'h0FADF0EF);
        check_eq("commit2_upd", upd_cnt - u0, 1);
        u0 = upd_cnt;
        axi_write(32'h04, 32'h1, 4'hF, rs, upd);
        check_eq("commit_nochange_upd", upd_cnt - u0, 1);

        // W three cycles ahead of AW, BREADY held off for five cycles
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1; awaddr = 32'h10;
        step(1); wvalid = 0;
        check_eq("hs_wready_low", WREADY, 0);
        step(2);
        awvalid = 1;
        step(1); awvalid = 0;
        check_eq("hs_awready_low", AWREADY, 0);
        wait_b();
        check_eq("hs_bresp", BRESP, 2'd0);
        stable = 0;
        repeat (5) begin step(1); if (BVALID === 1'b1 && BRESP === 2'd0) stable++; end
        check_eq("hs_bvalid_held", stable, 5);
        bready = 1; step(1); bready = 0;
        check_eq("hs_bvalid_drop", BVALID, 0);
        check_eq("hs_readys_back", {AWREADY, WREADY}, 2'b11);
        axi_read(32'h10, rd, rs);
        check_eq("hs_ppg_written", rd, 32'hCAFEF00D);

        // FRAME_COUNT sampled at the AR handshake, RREADY delayed
        FRAME_COUNT = {32'h11112222, 32'h33334444};
        check_eq("ar_ready_idle", ARREADY, 1);
        araddr = 32'h84; arvalid = 1;
        step(1); arvalid = 0;
        FRAME_COUNT = {32'h55556666, 32'h77778888};
        stable = 0;
        repeat (4) begin
            if (RVALID === 1'b1 && RDATA === 32'h11112222 && ARREADY === 1'b0) stable++;
            step(1);
        end
        check_eq("fc_rd_held", stable, 4);
        check_eq("fc_rd_data", RDATA, 32'h11112222);
        check_eq("fc_rd_resp", RRESP, 2'd0);
        rready = 1; step(1); rready = 0;
        check_eq("fc_rvalid_drop", RVALID, 0);

        // Async reset while the write response is pending
        wr_issue(32'h08, 32'h77, 4'hF);
        wait_b();
        #3 resetn = 0;
        #1;
        check_eq("arst_bvalid", BVALID, 0);
        check_eq("arst_frame", FRAME_SIZE, 0);
        check_eq("arst_hdr", SENSOR_HDR, 32'h0FAAF0AA);
        check_eq("arst_rgn", RGN_ADDR[63:0], 64'h0);
        step(2);
        resetn = 1;
        bready = 1;
        cyc = 0;
        repeat (6) begin step(1); if (BVALID !== 1'b0) cyc++; end
        bready = 0;
        check_eq("arst_no_stray_b", cyc, 0);
        axi_read(32'h08, rd, rs);
        check_eq("arst_stg_frame", rd, 0);
        axi_read(32'h20, rd, rs);
        check_eq("arst_stg_rgn", rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
